// File: rtl/cp0_tlb_param_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes and the EntryLo layout
// used by the TLB-aware coprocessor-0 register file.
package cp0_tlb_param_pkg;

   localparam logic [4:0] CP0_INDEX    = 5'd0;
   localparam logic [4:0] CP0_RANDOM   = 5'd1;
   localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_WIRED    = 5'd6;
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   // Bit order matches EntryLo[25:0]: PFN, C, D, V, G
   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
      logic        g;
   } entryLo_t;

   function automatic logic isAddrExc(input logic [4:0] code);
      return (code >= EXC_MOD) && (code <= EXC_ADES);
   endfunction

   function automatic logic isTlbExc(input logic [4:0] code);
      return (code >= EXC_MOD) && (code <= EXC_TLBS);
   endfunction

   function automatic logic [31:0] packEntryLo(input entryLo_t e);
      return {6'b0, e};
   endfunction

endpackage

// File: rtl/cp0_tlb_param_timer.sv
// CP0 timer: Count prescaler, Count/Compare registers and the sticky
// timer-interrupt flag that only an mtc0 to Compare clears.
module cp0_tlb_param_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_countWe,
   input  logic        i_compareWe,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_ti
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [31:0]   r_count;
   logic [31:0]   r_compare;
   logic          r_ti;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_presc <= '0;
         r_count <= '0;
      end else if (i_countWe) begin
         r_count <= i_wdata;
         r_presc <= '0;
      end else if (r_presc == PRESC_MAX) begin
         r_presc <= '0;
         r_count <= r_count + 32'd1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // A Compare write acknowledges the interrupt even if the match persists
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_compare <= '0;
         r_ti      <= 1'b0;
      end else begin
         if (i_compareWe) begin
            r_compare <= i_wdata;
         end
         if (i_compareWe) begin
            r_ti <= 1'b0;
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign o_count   = r_count;
   assign o_compare = r_compare;
   assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_tlb_param.sv
// Parametrised CP0 register file with TLB management registers.
// Define CP0_RANDOM_EN to build the Random/Wired registers for tlbwr.
module cp0_tlb_param
   import cp0_tlb_param_pkg::*;
#(
   parameter int TLBNUM     = 16,
   parameter int HW_INT_NUM = 6,
   parameter int COUNT_DIV  = 2,
   localparam int IW        = $clog2(TLBNUM)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [4:0]            raddr,
   output logic [31:0]           rdata,
   input  logic                  mtc0_we,
   input  logic [4:0]            mtc0_waddr,
   input  logic [31:0]           mtc0_wdata,
   input  logic                  ex_valid,
   input  logic [4:0]            ex_code,
   input  logic [31:0]           ex_pc,
   input  logic                  ex_bd,
   input  logic [31:0]           ex_badvaddr,
   input  logic                  eret,
   input  logic [HW_INT_NUM-1:0] hw_int,
   output logic                  int_req,
   output logic [31:0]           epc_out,
   input  logic                  tlbp_we,
   input  logic                  tlbp_found,
   input  logic [IW-1:0]         tlbp_index,
   input  logic                  tlbr_we,
   input  logic [18:0]           r_vpn2,
   input  logic [7:0]            r_asid,
   input  logic                  r_g,
   input  logic [19:0]           r_pfn0,
   input  logic [2:0]            r_c0,
   input  logic                  r_d0,
   input  logic                  r_v0,
   input  logic [19:0]           r_pfn1,
   input  logic [2:0]            r_c1,
   input  logic                  r_d1,
   input  logic                  r_v1,
   output logic [IW-1:0]         w_index,
   output logic [IW-1:0]         rand_index,
   output logic [18:0]           w_vpn2,
   output logic [7:0]            w_asid,
   output logic                  w_g,
   output logic [19:0]           w_pfn0,
   output logic [2:0]            w_c0,
   output logic                  w_d0,
   output logic                  w_v0,
   output logic [19:0]           w_pfn1,
   output logic [2:0]            w_c1,
   output logic                  w_d1,
   output logic                  w_v1
);

   logic [7:0]            r_statusIm;
   logic                  r_statusExl;
   logic                  r_statusIe;
   logic                  r_causeBd;
   logic [4:0]            r_causeExcCode;
   logic [1:0]            r_causeIpSw;
   logic [31:0]           r_epc;
   logic [31:0]           r_badVAddr;
   logic [18:0]           r_entryHiVpn2;
   logic [7:0]            r_entryHiAsid;
   entryLo_t              r_entryLo0;
   entryLo_t              r_entryLo1;
   logic                  r_indexP;
   logic [IW-1:0]         r_index;
   logic [HW_INT_NUM-1:0] r_hwSync1;
   logic [HW_INT_NUM-1:0] r_hwSync2;
   logic                  r_intReq;

   logic        w_mtc0Status;
   logic        w_mtc0Cause;
   logic        w_mtc0Epc;
   logic        w_mtc0EntryHi;
   logic        w_mtc0EntryLo0;
   logic        w_mtc0EntryLo1;
   logic        w_mtc0Index;
   logic        w_mtc0Count;
   logic        w_mtc0Compare;
   logic [31:0] w_count;
   logic [31:0] w_compare;
   logic        w_ti;
   logic [5:0]  w_hwExt;
   logic [7:0]  w_ip;
   logic [31:0] w_randomRead;
   logic [31:0] w_wiredRead;

   assign w_mtc0Status   = mtc0_we && (mtc0_waddr == CP0_STATUS);
   assign w_mtc0Cause    = mtc0_we && (mtc0_waddr == CP0_CAUSE);
   assign w_mtc0Epc      = mtc0_we && (mtc0_waddr == CP0_EPC);
   assign w_mtc0EntryHi  = mtc0_we && (mtc0_waddr == CP0_ENTRYHI);
   assign w_mtc0EntryLo0 = mtc0_we && (mtc0_waddr == CP0_ENTRYLO0);
   assign w_mtc0EntryLo1 = mtc0_we && (mtc0_waddr == CP0_ENTRYLO1);
   assign w_mtc0Index    = mtc0_we && (mtc0_waddr == CP0_INDEX);
   assign w_mtc0Count    = mtc0_we && (mtc0_waddr == CP0_COUNT);
   assign w_mtc0Compare  = mtc0_we && (mtc0_waddr == CP0_COMPARE);

   cp0_tlb_param_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_cp0_timer (
      .clk         (clk),
      .resetn      (resetn),
      .i_countWe   (w_mtc0Count),
      .i_compareWe (w_mtc0Compare),
      .i_wdata     (mtc0_wdata),
      .o_count     (w_count),
      .o_compare   (w_compare),
      .o_ti        (w_ti)
   );

   // Exception state: a nested exception keeps the original EPC and BD
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_statusIm     <= '0;
         r_statusExl    <= 1'b0;
         r_statusIe     <= 1'b0;
         r_causeBd      <= 1'b0;
         r_causeExcCode <= '0;
         r_causeIpSw    <= '0;
         r_epc          <= '0;
         r_badVAddr     <= '0;
      end else begin
         if (ex_valid) begin
            r_statusExl <= 1'b1;
         end else if (eret) begin
            r_statusExl <= 1'b0;
         end else if (w_mtc0Status) begin
            r_statusExl <= mtc0_wdata[1];
         end
         if (w_mtc0Status) begin
            r_statusIm <= mtc0_wdata[15:8];
            r_statusIe <= mtc0_wdata[0];
         end
         if (ex_valid && !r_statusExl) begin
            r_epc     <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
            r_causeBd <= ex_bd;
         end else if (w_mtc0Epc) begin
            r_epc <= mtc0_wdata;
         end
         if (ex_valid) begin
            r_causeExcCode <= ex_code;
         end
         if (w_mtc0Cause) begin
            r_causeIpSw <= mtc0_wdata[9:8];
         end
         if (ex_valid && isAddrExc(ex_code)) begin
            r_badVAddr <= ex_badvaddr;
         end
      end
   end

   // TLB exceptions preload EntryHi.VPN2 so the refill handler can use it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_entryHiVpn2 <= '0;
         r_entryHiAsid <= '0;
         r_entryLo0    <= '0;
         r_entryLo1    <= '0;
      end else begin
         if (ex_valid && isTlbExc(ex_code)) begin
            r_entryHiVpn2 <= ex_badvaddr[31:13];
         end else if (w_mtc0EntryHi) begin
            r_entryHiVpn2 <= mtc0_wdata[31:13];
         end else if (tlbr_we) begin
            r_entryHiVpn2 <= r_vpn2;
         end
         if (w_mtc0EntryHi) begin
            r_entryHiAsid <= mtc0_wdata[7:0];
         end else if (tlbr_we) begin
            r_entryHiAsid <= r_asid;
         end
         if (w_mtc0EntryLo0) begin
            r_entryLo0 <= entryLo_t'(mtc0_wdata[25:0]);
         end else if (tlbr_we) begin
            r_entryLo0 <= '{pfn: r_pfn0, c: r_c0, d: r_d0, v: r_v0, g: r_g};
         end
         if (w_mtc0EntryLo1) begin
            r_entryLo1 <= entryLo_t'(mtc0_wdata[25:0]);
         end else if (tlbr_we) begin
            r_entryLo1 <= '{pfn: r_pfn1, c: r_c1, d: r_d1, v: r_v1, g: r_g};
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_indexP <= 1'b0;
         r_index  <= '0;
      end else if (w_mtc0Index) begin
         r_index <= mtc0_wdata[IW-1:0];
      end else if (tlbp_we) begin
         r_indexP <= ~tlbp_found;
         if (tlbp_found) begin
            r_index <= tlbp_index;
         end
      end
   end

   // Unused upper IP lines read 0; the timer shares IP7 with the last line
   assign w_hwExt = 6'(r_hwSync2);
   assign w_ip    = {w_hwExt[5] | w_ti, w_hwExt[4:0], r_causeIpSw};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hwSync1 <= '0;
         r_hwSync2 <= '0;
         r_intReq  <= 1'b0;
      end else begin
         r_hwSync1 <= hw_int;
         r_hwSync2 <= r_hwSync1;
         r_intReq  <= (|(w_ip & r_statusIm)) & r_statusIe & ~r_statusExl;
      end
   end

`ifdef CP0_RANDOM_EN
   localparam logic [IW-1:0] RANDOM_TOP = IW'(TLBNUM - 1);

   logic [IW-1:0] r_random;
   logic [IW-1:0] r_wired;
   logic          w_mtc0Wired;

   assign w_mtc0Wired = mtc0_we && (mtc0_waddr == CP0_WIRED);

   // Random walks down to Wired, then restarts from the top entry
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_random <= RANDOM_TOP;
         r_wired  <= '0;
      end else if (w_mtc0Wired) begin
         r_wired  <= mtc0_wdata[IW-1:0];
         r_random <= RANDOM_TOP;
      end else if (r_random <= r_wired) begin
         r_random <= RANDOM_TOP;
      end else begin
         r_random <= r_random - 1'b1;
      end
   end

   assign rand_index   = r_random;
   assign w_randomRead = 32'(r_random);
   assign w_wiredRead  = 32'(r_wired);
`else
   assign rand_index   = '0;
   assign w_randomRead = '0;
   assign w_wiredRead  = '0;
`endif

   always_comb begin
      rdata = '0;
      case (raddr)
         CP0_INDEX:    rdata = {r_indexP, 31'(r_index)};
         CP0_RANDOM:   rdata = w_randomRead;
         CP0_ENTRYLO0: rdata = packEntryLo(r_entryLo0);
         CP0_ENTRYLO1: rdata = packEntryLo(r_entryLo1);
         CP0_WIRED:    rdata = w_wiredRead;
         CP0_BADVADDR: rdata = r_badVAddr;
         CP0_COUNT:    rdata = w_count;
         CP0_ENTRYHI:  rdata = {r_entryHiVpn2, 5'b0, r_entryHiAsid};
         CP0_COMPARE:  rdata = w_compare;
         CP0_STATUS:   rdata = {9'b0, 1'b1, 6'b0, r_statusIm, 6'b0, r_statusExl, r_statusIe};
         CP0_CAUSE:    rdata = {r_causeBd, w_ti, 14'b0, w_ip, 1'b0, r_causeExcCode, 2'b0};
         CP0_EPC:      rdata = r_epc;
         default:      rdata = '0;
      endcase
   end

   assign int_req = r_intReq;
   assign epc_out = r_epc;
   assign w_index = r_index;
   assign w_vpn2  = r_entryHiVpn2;
   assign w_asid  = r_entryHiAsid;
   assign w_g     = r_entryLo0.g & r_entryLo1.g;
   assign w_pfn0  = r_entryLo0.pfn;
   assign w_c0    = r_entryLo0.c;
   assign w_d0    = r_entryLo0.d;
   assign w_v0    = r_entryLo0.v;
   assign w_pfn1  = r_entryLo1.pfn;
   assign w_c1    = r_entryLo1.c;
   assign w_d1    = r_entryLo1.d;
   assign w_v1    = r_entryLo1.v;

endmodule

// File: doc/cp0_tlb_param.md
Name: cp0_tlb_param

Overview:
- Parametrised second-generation coprocessor-0 register file for the MIPS pipeline.
- Holds exception state (EPC, Cause, Status, BadVAddr), timer (Count/Compare) and TLB-management registers (Index, EntryHi, EntryLo0/1, Random, Wired), sized to a configurable TLB depth.
- Adds hardware interrupt sampling, an interrupt-request output, a Count prescaler and automatic EntryHi/BadVAddr capture on TLB exceptions.
- Sits beside the WB stage: takes mtc0/exception/eret/tlbp/tlbr commits and feeds mfc0, the TLB write port and the fetch redirect logic.

Parameters:
- TLBNUM, 16, TLB entries; index width IW = log2(TLBNUM), legal 2..64.
- HW_INT_NUM, 6, external interrupt lines mapped to Cause.IP[2+HW_INT_NUM-1:2]; maximum 6.
- COUNT_DIV, 2, core cycles per Count increment; must be at least 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- raddr  in  5  mfc0 register number (sel=0 only).
- rdata  out  32  combinational read data; unmapped addresses read 0.
- mtc0_we  in  1  mtc0 commit.
- mtc0_waddr  in  5  target register.
- mtc0_wdata  in  32  write data.
- ex_valid  in  1  exception commit from WB.
- ex_code  in  5  ExcCode.
- ex_pc  in  32  PC of the faulting instruction.
- ex_bd  in  1  faulting instruction is in a delay slot.
- ex_badvaddr  in  32  faulting address.
- eret  in  1  eret commit.
- hw_int  in  HW_INT_NUM  level-sensitive external interrupts.
- int_req  out  1  registered interrupt request to WB.
- epc_out  out  32  EPC value for eret redirect.
- tlbp_we, tlbp_found, tlbp_index  in  1/1/IW  tlbp result.
- tlbr_we, r_vpn2[19], r_asid[8], r_g, r_pfn0[20], r_c0[3], r_d0, r_v0, r_pfn1[20], r_c1[3], r_d1, r_v1  in  tlbr entry data.
- w_index  out  IW  Index.Index, for tlbwi.
- rand_index  out  IW  Random.Random, for tlbwr.
- w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  out  TLB write data.
- w_g = G0 AND G1.

Behaviour:
- Reset (async, resetn=0):
  - Status: BEV=1, IM=0, EXL=0, IE=0.
  - Cause = 0; Index = 0 with P=0; EntryHi/Lo = 0; BadVAddr = 0; Count = 0; Compare = 0.
  - Prescaler = 0; Random = TLBNUM-1; Wired = 0.
  - int_req = 0; EPC = 0.
- Register numbers: Index 0, Random 1, EntryLo0 2, EntryLo1 3, Wired 6, BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14.
- Write priority per field, highest first: ex_valid, eret, mtc0, tlbr/tlbp, autonomous update.
- Exception commit:
  - Condition: ex_valid=1 and Status.EXL=0. Then EPC <= ex_bd ? ex_pc-4 : ex_pc, and Cause.BD <= ex_bd.
  - Whenever ex_valid=1, regardless of EXL: Cause.ExcCode <= ex_code and EXL <= 1.
  - Codes 1,2,3,4,5 (Mod, TLBL, TLBS, AdEL, AdES): BadVAddr <= ex_badvaddr.
  - Codes 1,2,3 only: EntryHi.VPN2 <= ex_badvaddr[31:13].
- eret: EXL <= 0.
- mtc0 writable fields:
  - Status: IM, EXL, IE.
  - Cause: IP[1:0] (software interrupts only).
  - EntryHi: VPN2, ASID.
  - EntryLo: PFN[25:6], C, D, V, G.
  - Index: Index[IW-1:0].
  - Wired: [IW-1:0].
  - Compare, Count, EPC: all bits.
  - All other bits read 0.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments on wrap.
  - mtc0 Count loads the value and resets the prescaler.
  - Count wraps at 2^32.
  - Cause.TI sets the cycle after Count==Compare and holds until an mtc0 to Compare. That clear wins over a same-cycle set.
- Interrupt inputs:
  - hw_int passes through a 2-flop synchroniser into Cause.IP[2+HW_INT_NUM-1:2].
  - IP[7] = IP_hw[5] OR TI (when HW_INT_NUM=6).
- int_req is registered: int_req <= |(IP & IM) & IE & ~EXL. One cycle latency from the IP/IM/IE/EXL change.
- tlbp_we:
  - found=1: P <= 0, Index <= tlbp_index.
  - found=0: P <= 1, Index unchanged.
- tlbr_we loads EntryHi.VPN2, EntryHi.ASID and both EntryLo from r_*; G0 = G1 = r_g.

Optional Feature:
- CP0_RANDOM_EN defined:
  - Random decrements every cycle.
  - At Wired it wraps to TLBNUM-1. If Random < Wired it also reloads to TLBNUM-1.
  - mtc0 to Wired sets Random <= TLBNUM-1 the same cycle.
  - Random reads at register 1; Wired reads/writes at register 6.
- Not defined:
  - Random and Wired are absent; registers 1 and 6 read 0.
  - rand_index is tied to 0.

Decomposition:
- Shared package (the existing CP0/ExcCode header): CP0 register numbers (new RANDOM, WIRED); ExcCode constants MOD, TLBL, TLBS, ADEL, ADES, INT.
- One sub-module, cp0_timer: prescaler, Count, Compare and TI logic.

Test Plan:
- Reset, then mfc0 Status -> 0x00400000. mfc0 Random (CP0_RANDOM_EN, TLBNUM=16) -> 15.
- ex_valid with code TLBL, ex_pc=0xBFC00100, ex_bd=1, badvaddr=0x00402ABC -> EPC=0xBFC000FC, Cause=0x80000008, BadVAddr=0x00402ABC, EntryHi.VPN2=0x00201. A second exception while EXL=1 leaves EPC unchanged.
- Timer, COUNT_DIV=2: mtc0 Compare=5, Count=0 -> Count reaches 5 after 10 cycles; TI=1 next cycle. With IM[7]=1 and IE=1, int_req=1 one cycle later. mtc0 Compare clears TI.
- hw_int[1] pulses high for 3 cycles with IM[3]=1, IE=1, EXL=0 -> Cause.IP[3]=1 two cycles after the assertion; int_req follows one cycle later.
- tlbp not found -> Index=0x80000000 | old index. tlbr with r_g=1, r_pfn0=0x12345 -> EntryLo0=0x0048D141 | C/D/V bits.
- Wired=4 (CP0_RANDOM_EN) -> Random cycles 15..4 and never below 4. Same-cycle ex_valid and mtc0 to Status -> EXL=1.
